// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, state encoding and types for the round-robin arbiter
package arb_pkg;
    localparam int N_REQ       = 4;
    localparam int TIMEOUT_DEF = 16;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    typedef logic [N_REQ-1:0]         req_t;
    typedef logic [$clog2(N_REQ)-1:0] idx_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request at or after ptr, searching upward with wraparound
module rr_priority_pick
    import arb_pkg::*;
(
    input  req_t req,
    input  idx_t ptr,
    output idx_t idx,
    output logic any
);
    always_comb begin
        idx = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[ptr + idx_t'(k)]) idx = ptr + idx_t'(k);
        end
    end
    assign any = |req;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered one-hot grant and forced release on hold timeout
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N       = N_REQ,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic [1:0]   grant_idx,
    output logic         grant_valid,
    output logic         timeout
);
    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);
    logic [0:0]   state_q, state_d;
    idx_t         ptr_q, ptr_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [N-1:0] grant_q, grant_d;
    idx_t         idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         timeout_q, timeout_d;
    idx_t         pick_idx;
    logic         pick_any;
    logic         rel_norm, rel_lim;
    rr_priority_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );
    assign rel_norm = done | ~req[idx_q];
    assign rel_lim  = cnt_q == CNT_MAX;
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (pick_any) begin
                state_d           = BUSY;
                grant_d           = '0;
                grant_d[pick_idx] = 1'b1;
                idx_d             = pick_idx;
                valid_d           = 1'b1;
                cnt_d             = '0;
            end
        end else if (rel_norm || rel_lim) begin
            state_d   = IDLE;
            grant_d   = '0;
            valid_d   = 1'b0;
            ptr_d     = idx_q + 2'd1;
            timeout_d = rel_lim & ~rel_norm;
        end else begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end
    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: scenario tasks plus randomized traffic against a cycle-level arbitration model
module tb_rr_arbiter;
    localparam int TO = 16;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       done = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    int n_checks = 0;
    int n_fail = 0;
    int m_owner = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_last = 0;
    bit m_to = 1'b0;

    rr_arbiter #(.N(4), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_checks++;
        if (!$onehot0(grant) || grant_valid !== (grant != 4'b0000)) begin
            n_fail++;
            $display("FAIL onehot_valid: grant=%b grant_valid=%b, need one-hot-or-zero and valid==(grant!=0)", grant, grant_valid);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant();
        return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    endfunction

    function automatic logic [1:0] exp_idx();
        return 2'((m_owner < 0) ? m_last : m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr = 0;
        m_cnt = 0;
        m_last = 0;
        m_to = 1'b0;
    endtask

    task automatic tick();
        logic [3:0] r;
        logic d;
        bit norm, lim;
        r = req;
        d = done;
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (m_owner < 0) begin
            m_to = 1'b0;
            if (r != 4'b0000) begin
                m_owner = pick(r, m_ptr);
                m_cnt = 0;
            end
        end else begin
            norm = d || !r[m_owner];
            lim = (m_cnt == TO - 1);
            m_to = 1'b0;
            if (norm || lim) begin
                m_to = lim && !norm;
                m_ptr = (m_owner + 1) % 4;
                m_last = m_owner;
                m_owner = -1;
            end else if (m_cnt < 255) m_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        done = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_checks++;
        if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
        n_checks++;
        if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        logic [3:0] seq [8];
        logic [3:0] want [5];
        logic [3:0] prev;
        int ns, zrun;
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000; want[4] = 4'b0001;
        ns = 0;
        zrun = 0;
        prev = 4'b0000;
        req = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            done = (c % 3 == 2);
            tick();
            n_checks++;
            if ({grant, grant_idx, timeout} !== {exp_grant(), exp_idx(), m_to}) begin
                n_fail++;
                $display("FAIL rotation_cycle%0d: grant=%b idx=%0d to=%b want %b %0d %b", c, grant, grant_idx, timeout, exp_grant(), exp_idx(), m_to);
            end
            if (grant == 4'b0000) zrun++;
            else if (prev == 4'b0000) begin
                if (ns > 0) begin
                    n_checks++;
                    if (zrun != 1) begin n_fail++; $display("FAIL rotation_gap: got %0d idle cycles want 1", zrun); end
                end
                if (ns < 8) seq[ns] = grant;
                ns++;
                zrun = 0;
            end
            prev = grant;
        end
        done = 1'b0;
        n_checks++;
        if (ns != 5) begin n_fail++; $display("FAIL rotation_count: got %0d grants want 5", ns); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= ns || seq[i] !== want[i]) begin
                n_fail++;
                $display("FAIL rotation_seq%0d: got %b want %b", i, (i < ns) ? seq[i] : 4'bxxxx, want[i]);
            end
        end
        req = 4'b0000;
        repeat (2) tick();
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        n_checks++;
        if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", grant); end
        n_checks++;
        if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL single_idx: got %0d want 2", grant_idx); end
        req = 4'b0000;
        tick();
        n_checks++;
        if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_drop: got %b want 0000", grant); end
        req = 4'b1111;
        tick();
        n_checks++;
        if (grant !== 4'b1000) begin n_fail++; $display("FAIL single_next: got %b want 1000", grant); end
        req = 4'b0000;
        repeat (2) tick();
    endtask

    task automatic test_timeout();
        int high;
        req = 4'b0001;
        tick();
        high = 0;
        while (grant == 4'b0001 && high < 40) begin
            high++;
            tick();
        end
        n_checks++;
        if (high != TO) begin n_fail++; $display("FAIL timeout_hold: got %0d cycles want %0d", high, TO); end
        n_checks++;
        if (timeout !== 1'b1 || grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_pulse: timeout=%b grant=%b want 1 0000", timeout, grant);
        end
        tick();
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_width: got %b want 0", timeout); end
        req = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic test_done_at_limit();
        for (int v = 0; v < 2; v++) begin
            req = 4'b0001;
            tick();
            repeat (TO - 1) tick();
            n_checks++;
            if (grant !== 4'b0001) begin n_fail++; $display("FAIL limit_held%0d: got %b want 0001", v, grant); end
            if (v == 0) done = 1'b1;
            else req = 4'b0000;
            tick();
            n_checks++;
            if (grant !== 4'b0000 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL limit_release%0d: grant=%b timeout=%b want 0000 0", v, grant, timeout);
            end
            done = 1'b0;
            req = 4'b0000;
            repeat (2) tick();
        end
    endtask

    task automatic test_async_reset();
        req = 4'b0010;
        tick();
        n_checks++;
        if (grant !== 4'b0010) begin n_fail++; $display("FAIL areset_pre: got %b want 0010", grant); end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL areset_now: grant=%b valid=%b idx=%0d want 0000 0 0", grant, grant_valid, grant_idx);
        end
        tick();
        rst_n = 1'b1;
        req = 4'b0011;
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin n_fail++; $display("FAIL areset_first: got %b want 0001", grant); end
        req = 4'b0000;
        repeat (2) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 5) == 0);
            tick();
            n_checks++;
            if ({grant, grant_idx, grant_valid, timeout} !== {exp_grant(), exp_idx(), m_owner >= 0, m_to}) begin
                n_fail++;
                $display("FAIL random_cycle%0d: grant=%b idx=%0d valid=%b to=%b want %b %0d %b %b",
                         c, grant, grant_idx, grant_valid, timeout, exp_grant(), exp_idx(), m_owner >= 0, m_to);
            end
        end
        done = 1'b0;
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single();
        test_timeout();
        test_done_at_limit();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
